// File: rtl/maxpool_stream.sv
// Streaming 1-D max-pooling stage: reduces each N-sample frame to ceil(N/POOL)
// signed maxima over non-overlapping windows, emitted through a one-deep output register.
module maxpool_stream #(
  parameter int unsigned T    = 20,
  parameter int unsigned N    = 13,
  parameter int unsigned POOL = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [T-1:0] x_data,
  input  logic                x_valid,
  output logic                x_ready,
  output logic signed [T-1:0] y_data,
  output logic                y_valid,
  input  logic                y_ready,
  output logic                y_last
);

  localparam int unsigned KW = $clog2(POOL) + 1;
  localparam int unsigned NW = $clog2(N) + 1;

  logic [KW-1:0]        r_k;
  logic [NW-1:0]        r_n;
  logic signed [T-1:0]  r_best;

  logic                 w_accept;
  logic                 w_k_last;
  logic                 w_n_last;
  logic                 w_close;
  logic signed [T-1:0]  w_cand;

  // Stall only while the output register is full and not draining.
  assign x_ready  = ~y_valid | y_ready;
  assign w_accept = x_valid & x_ready;
  assign w_k_last = (r_k == KW'(POOL - 1));
  assign w_n_last = (r_n == NW'(N - 1));
  assign w_close  = w_accept & (w_k_last | w_n_last);

  // First sample of a window seeds the max; ties keep the stored value.
  always_comb begin
    w_cand = x_data;
    if ((r_k != '0) && (r_best >= x_data)) begin
      w_cand = r_best;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_k     <= '0;
      r_n     <= '0;
      r_best  <= '0;
      y_data  <= '0;
      y_valid <= 1'b0;
      y_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_n <= w_n_last ? '0 : r_n + NW'(1);
        if (w_close) begin
          r_k <= '0;
        end else begin
          r_best <= w_cand;
          r_k    <= r_k + KW'(1);
        end
      end
      // A closing sample reloads the output even while it drains, so no bubble.
      if (w_close) begin
        y_data  <= w_cand;
        y_valid <= 1'b1;
        y_last  <= w_n_last;
      end else if (y_valid && y_ready) begin
        y_valid <= 1'b0;
        y_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_maxpool_stream.sv
// Self-checking bench for maxpool_stream: directed test-plan cases plus randomized
// traffic scored against a frame/window arithmetic reference model.
module tb_maxpool_stream;

  localparam int unsigned T    = 20;
  localparam int unsigned N    = 13;
  localparam int unsigned POOL = 2;

  typedef struct {
    int d;
    int l;
  } out_t;

  logic                clk;
  logic                reset;
  logic signed [T-1:0] x_data;
  logic                x_valid;
  logic                x_ready;
  logic signed [T-1:0] y_data;
  logic                y_valid;
  logic                y_ready;
  logic                y_last;

  int   n_vec;
  int   n_err;
  int   rdy_mode;
  int   m_pos;
  int   m_best;
  bit   hold_chk;
  bit   ramp_on;
  int   xr_drop;
  out_t exp_q[$];
  out_t obs_q[$];

  maxpool_stream #(.T(T), .N(N), .POOL(POOL)) dut (
    .clk    (clk),
    .reset  (reset),
    .x_data (x_data),
    .x_valid(x_valid),
    .x_ready(x_ready),
    .y_data (y_data),
    .y_valid(y_valid),
    .y_ready(y_ready),
    .y_last (y_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Consumer ready pattern: 0 always, 1 never, 2 toggle, 3 random.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       y_ready = 1'b1;
      1:       y_ready = 1'b0;
      2:       y_ready = ~y_ready;
      default: y_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Reference model and scoreboard, sampled mid-cycle so handshakes are stable.
  always @(negedge clk) begin
    out_t e;
    out_t o;
    int   k;
    bit   pushed;
    if (reset) begin
      m_pos    = 0;
      m_best   = 0;
      hold_chk = 1'b0;
      exp_q.delete();
    end else begin
      if (hold_chk) chk("no_bubble_y_valid", int'(y_valid), 1);
      hold_chk = 1'b0;
      if (ramp_on && !x_ready) xr_drop++;
      if (y_valid && y_ready) begin
        o.d = int'(y_data);
        o.l = int'(y_last);
        obs_q.push_back(o);
        if (exp_q.size() == 0) begin
          chk("spurious_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("y_data", o.d, e.d);
          chk("y_last", o.l, e.l);
        end
      end
      if (x_valid && x_ready) begin
        pushed = 1'b0;
        k = m_pos % POOL;
        if (k == 0 || int'(x_data) > m_best) m_best = int'(x_data);
        if (k == POOL - 1 || m_pos == N - 1) begin
          e.d = m_best;
          e.l = (m_pos == N - 1) ? 1 : 0;
          exp_q.push_back(e);
          pushed = 1'b1;
        end
        m_pos = (m_pos == N - 1) ? 0 : m_pos + 1;
        if (pushed && y_valid && y_ready) hold_chk = 1'b1;
      end
    end
  end

  task automatic send(input int v);
    bit r;
    int budget;
    x_data  = T'(v);
    x_valid = 1'b1;
    budget  = 0;
    forever begin
      @(negedge clk);
      r = x_ready;
      @(posedge clk);
      #1;
      if (r) break;
      budget++;
      if (budget > 200) begin
        chk("send_timeout", budget, 0);
        break;
      end
    end
    x_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    x_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    x_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_y_valid", int'(y_valid), 0);
    chk("rst_y_last", int'(y_last), 0);
    chk("rst_y_data", int'(y_data), 0);
    chk("rst_x_ready", int'(x_ready), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    obs_q.delete();
  endtask

  task automatic drain();
    int budget;
    rdy_mode = 0;
    budget   = 0;
    while (budget < 200) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !y_valid) break;
      budget++;
    end
    chk("drain_pending", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ramp_exp[7];
    int sgn_in[6];
    int sgn_exp[3];
    int lasts;
    logic signed [T-1:0] s;

    n_vec    = 0;
    n_err    = 0;
    rdy_mode = 0;
    ramp_on  = 1'b0;
    xr_drop  = 0;
    m_pos    = 0;
    m_best   = 0;
    hold_chk = 1'b0;
    x_data   = '0;
    x_valid  = 1'b0;
    y_ready  = 1'b1;
    reset    = 1'b1;

    @(negedge clk);
    chk("init_y_valid", int'(y_valid), 0);
    chk("init_y_data", int'(y_data), 0);
    chk("init_x_ready", int'(x_ready), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Ramp 1..13 with consumer always ready.
    ramp_exp = '{2, 4, 6, 8, 10, 12, 13};
    obs_q.delete();
    ramp_on = 1'b1;
    for (int i = 1; i <= 13; i++) send(i);
    drain();
    ramp_on = 1'b0;
    chk("ramp_x_ready_drops", xr_drop, 0);
    chk("ramp_count", obs_q.size(), 7);
    for (int i = 0; i < 7 && i < obs_q.size(); i++) begin
      chk($sformatf("ramp_out%0d", i), obs_q[i].d, ramp_exp[i]);
      chk($sformatf("ramp_last%0d", i), obs_q[i].l, (i == 6) ? 1 : 0);
    end

    // Signed compares including the most negative value and a tie.
    pulse_reset();
    sgn_in  = '{-5, -7, -524288, -1, 7, 7};
    sgn_exp = '{-5, -1, 7};
    for (int i = 0; i < 6; i++) send(sgn_in[i]);
    drain();
    chk("signed_count", obs_q.size(), 3);
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      chk($sformatf("signed_out%0d", i), obs_q[i].d, sgn_exp[i]);
    end

    // Backpressure: output full and stuck, offered sample must not be taken.
    pulse_reset();
    rdy_mode = 1;
    send(1);
    send(2);
    x_data  = T'(3);
    x_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("bp_y_valid", int'(y_valid), 1);
      chk("bp_y_data", int'(y_data), 2);
      chk("bp_x_ready", int'(x_ready), 0);
    end
    @(posedge clk);
    #1;
    rdy_mode = 0;
    for (int i = 3; i <= 13; i++) send(i);
    drain();
    chk("bp_count", obs_q.size(), 7);
    chk("bp_out0", (obs_q.size() > 0) ? obs_q[0].d : -1, 2);
    chk("bp_out1", (obs_q.size() > 1) ? obs_q[1].d : -1, 4);

    // Reset mid-window discards the partial window.
    pulse_reset();
    send(100);
    pulse_reset();
    send(3);
    send(4);
    drain();
    chk("rstmid_count", obs_q.size(), 1);
    chk("rstmid_out0", (obs_q.size() > 0) ? obs_q[0].d : -1, 4);

    // Toggling ready with continuous input exercises drain+load in one cycle.
    pulse_reset();
    rdy_mode = 2;
    for (int i = 0; i < 2 * N; i++) begin
      s = T'($urandom);
      send(int'(s));
    end
    drain();
    chk("toggle_count", obs_q.size(), 14);

    // Two frames back-to-back, second all -9.
    pulse_reset();
    for (int i = 0; i < N; i++) begin
      s = T'($urandom);
      send(int'(s));
    end
    for (int i = 0; i < N; i++) send(-9);
    drain();
    chk("two_count", obs_q.size(), 14);
    lasts = 0;
    foreach (obs_q[i]) lasts += obs_q[i].l;
    chk("two_lasts", lasts, 2);
    chk("two_last7", (obs_q.size() > 6) ? obs_q[6].l : 0, 1);
    chk("two_last14", (obs_q.size() > 13) ? obs_q[13].l : 0, 1);
    for (int i = 7; i < 14 && i < obs_q.size(); i++) begin
      chk($sformatf("two_out%0d", i), obs_q[i].d, -9);
    end

    // Random traffic, gaps and consumer stalls over several frames.
    pulse_reset();
    rdy_mode = 3;
    for (int i = 0; i < 6 * N; i++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      case ($urandom_range(0, 7))
        0:       s = {1'b1, {(T-1){1'b0}}};
        1:       s = {1'b0, {(T-1){1'b1}}};
        default: s = T'($urandom);
      endcase
      send(int'(s));
    end
    drain();
    chk("rand_count", obs_q.size(), 6 * 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/maxpool_stream.md
# maxpool_stream

Streaming 1-D max-pooling stage that sits directly downstream of the convolution layer (`conv_16_4_20_1`) and consumes its `y_data`/`y_valid`/`y_ready` stream. Each frame of `N` signed samples is reduced to `ceil(N/POOL)` outputs over non-overlapping windows (stride = `POOL`); a trailing partial window is also reduced and emitted. The output is held in a one-deep register with valid/ready handshake, and the stage sustains one input per cycle while the consumer is ready.

## Interface
- `T`, 20, sample width in bits (signed two's complement, input and output)
- `N`, 13, samples per frame (conv output length 16-4+1); constraint `N >= 1`
- `POOL`, 2, window size and stride; constraint `1 <= POOL <= N`
- `clk`  input  1  clock; all state updates on rising edge
- `reset`  input  1  asynchronous, active-high; clears all state immediately
- `x_data`  input  T  signed input sample
- `x_valid`  input  1  `x_data` is valid
- `x_ready`  output  1  stage accepts a sample this cycle
- `y_data`  output  T  signed pooled maximum
- `y_valid`  output  1  `y_data` is valid
- `y_ready`  input  1  downstream accepts `y_data`
- `y_last`  output  1  qualifies `y_data` as the last pooled output of a frame

## Operation
- Accept: the stage accepts a sample when `x_valid && x_ready`; transfer out when `y_valid && y_ready`.
- `x_ready = ~y_valid | y_ready` (combinational). The stage stalls only when the output register is full and not draining.
- Window counter `k` (0..POOL-1, width `$clog2(POOL)+1`) and frame counter `n` (0..N-1, width `$clog2(N)+1`).
- Running max `best` (T bits, signed). On an accepted sample:
  - if `k==0`, the candidate is `x_data`;
  - otherwise the candidate is `max(best, x_data)` using a signed compare. On a tie the stored value is unchanged.
- Closing sample: an accepted sample with `k==POOL-1` or `n==N-1`.
  - Load `y_data <=` candidate and `y_valid <= 1`.
  - Set `y_last <= (n==N-1)`.
  - Reset `k` to 0.
- Non-closing sample: `best <=` candidate, `k <= k+1`.
- `n` increments on every accepted sample and wraps to 0 after `N-1`. `k` is also forced to 0 at the wrap, so every frame starts a fresh window.
- Output drain: if `y_valid && y_ready` and no closing sample is accepted in the same cycle, `y_valid <= 0` and `y_last <= 0`.
- Simultaneous drain and closing sample: the new value is loaded and `y_valid` stays 1. There is no bubble.
- While `y_valid && ~y_ready`, `y_data` and `y_last` must be held stable.
- Arithmetic is a compare and select only; no widening and no saturation is needed.
- `POOL==1` degenerates to a registered pass-through with `y_last` on each frame's final sample.

## Timing
- Reset values (asynchronous): `y_valid=0`, `y_last=0`, `y_data=0`, `best=0`, `k=0`, `n=0`. `x_ready` reads 1 during and after reset.
- Latency: the closing sample is accepted at edge E, and `y_valid`/`y_data` are visible after E (1 cycle).
- Throughput: one sample per cycle with `y_ready` held high. A full frame completes in N accept cycles, plus 1 cycle for the last output.
- Reset mid-window or mid-frame:
  - the partial window and the pending output are discarded, with no output emitted for them;
  - the next accepted sample is treated as frame position 0.
- An `x_valid` glitch while `x_ready=0` has no effect: no counter or `best` change.
- Back-to-back frames need no idle cycle between the last sample of frame f and the first sample of frame f+1.

## Test plan
- Ramp, defaults, `y_ready=1`: inputs 1..13 on consecutive cycles -> outputs 2,4,6,8,10,12,13 on consecutive cycles. `y_last=1` only with 13. `x_ready` stays 1 throughout.
- Signed compare: inputs -5,-7 / -524288,-1 / 7,7 -> outputs -5, -1, 7.
- Backpressure: hold `y_ready=0` after the first output.
  - Expect `y_valid=1` with `y_data=2` stable and `x_ready=0`, and no samples consumed.
  - Releasing `y_ready` resumes the stream with no loss or duplication.
- Simultaneous drain and load: `y_ready` toggles 1/0 every cycle with continuous input -> every pooled value delivered exactly once, in order; `y_valid` never drops while a new closing sample is accepted in the same cycle.
- Reset mid-window: accept 100, assert `reset` for 1 cycle, then send 3,4 -> first output is 4 (not 100), with `y_valid`, `y_last` and `y_data` at 0 during reset.
- Two frames back-to-back (26 samples, second frame all -9) -> 14 outputs; `y_last` on outputs 7 and 14; outputs 8..14 are all -9.
